// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath constants and load-size encodings
package mips_pkg;

    // Datapath defaults shared with the register file and hazard unit
    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_REG_W  = 5;

    // Load size encodings; 2'b11 is treated as a word load
    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    // Hard-wired zero register
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - sub-word lane select and sign/zero extension for loads
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] memData,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [1:0]  off,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane and extend it; off[0] is ignored for halves
    always_comb begin
        byte_lane = memData[{off, 3'b000} +: 8];
        half_lane = off[1] ? memData[31:16] : memData[15:0];
        result    = memData;
        case (size)
            LOAD_BYTE: result = {{24{~isUnsigned & byte_lane[7]}}, byte_lane};
            LOAD_HALF: result = {{16{~isUnsigned & half_lane[15]}}, half_lane};
            default:   result = memData;
        endcase
    end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB stage register, writeback mux, forward tap and retire counter
module mem_wb_writeback
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int REG_W  = MIPS_REG_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic              inRegWrite,
    input  logic              inMemToReg,
    input  logic [1:0]        inLoadSize,
    input  logic              inLoadUnsigned,
    input  logic [1:0]        inByteOff,
    input  logic [REG_W-1:0]  inRd,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] memData,
    output logic              regWrite,
    output logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] writeData,
    output logic              fwdValid,
    output logic [REG_W-1:0]  fwdRd,
    output logic [DATA_W-1:0] fwdData,
    output logic [CNT_W-1:0]  retireCount
);

    logic              valid_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic [1:0]        load_size_q;
    logic              load_unsigned_q;
    logic [1:0]        byte_off_q;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] load_data;
    logic [CNT_W-1:0]  retire_q;
    logic              write_en;

    // Stage register: flush beats stall beats capture; reset clears everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q         <= 1'b0;
            reg_write_q     <= 1'b0;
            mem_to_reg_q    <= 1'b0;
            load_size_q     <= 2'b00;
            load_unsigned_q <= 1'b0;
            byte_off_q      <= 2'b00;
            rd_q            <= '0;
            alu_q           <= '0;
            mem_q           <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q         <= inValid;
            reg_write_q     <= inRegWrite;
            mem_to_reg_q    <= inMemToReg;
            load_size_q     <= inLoadSize;
            load_unsigned_q <= inLoadUnsigned;
            byte_off_q      <= inByteOff;
            rd_q            <= inRd;
            alu_q           <= aluResult;
            mem_q           <= memData;
        end
    end

    // Count an instruction when it leaves WB; saturate instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (valid_q && !stall && !flush && (retire_q != '1)) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    load_align u_load_align (
        .memData    (mem_q),
        .size       (load_size_q),
        .isUnsigned (load_unsigned_q),
        .off        (byte_off_q),
        .result     (load_data)
    );

    // r0 is never written, so a write to it is squashed here
    assign write_en = valid_q && reg_write_q && (rd_q != REG_W'(REG_ZERO));

    assign regWrite    = write_en;
    assign rd          = rd_q;
    assign writeData   = mem_to_reg_q ? load_data : alu_q;
    assign fwdValid    = write_en;
    assign fwdRd       = rd_q;
    assign fwdData     = writeData;
    assign retireCount = retire_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - scoreboard bench for mem_wb_writeback
module tb_mem_wb_writeback;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          inValid = 1'b0;
    logic          inRegWrite = 1'b0;
    logic          inMemToReg = 1'b0;
    logic [1:0]    inLoadSize = 2'b00;
    logic          inLoadUnsigned = 1'b0;
    logic [1:0]    inByteOff = 2'b00;
    logic [RW-1:0] inRd = '0;
    logic [DW-1:0] aluResult = '0;
    logic [DW-1:0] memData = '0;
    logic          regWrite;
    logic [RW-1:0] rd;
    logic [DW-1:0] writeData;
    logic          fwdValid;
    logic [RW-1:0] fwdRd;
    logic [DW-1:0] fwdData;
    logic [CW-1:0] retireCount;

    mem_wb_writeback #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .inValid        (inValid),
        .inRegWrite     (inRegWrite),
        .inMemToReg     (inMemToReg),
        .inLoadSize     (inLoadSize),
        .inLoadUnsigned (inLoadUnsigned),
        .inByteOff      (inByteOff),
        .inRd           (inRd),
        .aluResult      (aluResult),
        .memData        (memData),
        .regWrite       (regWrite),
        .rd             (rd),
        .writeData      (writeData),
        .fwdValid       (fwdValid),
        .fwdRd          (fwdRd),
        .fwdData        (fwdData),
        .retireCount    (retireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        stall;
        bit        flush;
        bit        v;
        bit        rw;
        bit        m2r;
        bit [1:0]  sz;
        bit        uns;
        bit [1:0]  off;
        bit [4:0]  rd;
        bit [31:0] alu;
        bit [31:0] mem;
    } txn_t;

    typedef struct {
        int        cyc;
        bit        known;
        bit        rw;
        bit [4:0]  rd;
        bit [31:0] data;
        int        cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model of what sits in WB and how many have retired
    bit        m_valid = 0;
    bit        m_known = 1;
    bit        m_rw = 0;
    bit [4:0]  m_rd = 0;
    bit [31:0] m_data = 0;
    int        m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic bit [31:0] ref_load(bit [31:0] mem, bit [1:0] sz, bit uns, bit [1:0] off);
        longint v;
        if (sz == 2'd0) begin
            v = longint'(mem >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = longint'(mem >> ((off >= 2) ? 16 : 0)) % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(mem);
        end
        return v[31:0];
    endfunction

    function automatic txn_t idle();
        txn_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic txn_t alu_op(bit [4:0] r, bit [31:0] d);
        txn_t t;
        t = idle();
        t.v = 1; t.rw = 1; t.rd = r; t.alu = d; t.sz = 2'd2;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.rst   = ($urandom_range(0, 99) == 0);
        t.stall = ($urandom_range(0, 99) < 20);
        t.flush = ($urandom_range(0, 99) < 10);
        t.v     = ($urandom_range(0, 99) < 75);
        t.rw    = ($urandom_range(0, 99) < 80);
        t.m2r   = $urandom_range(0, 1);
        t.sz    = 2'($urandom_range(0, 3));
        t.uns   = $urandom_range(0, 1);
        t.off   = 2'($urandom_range(0, 3));
        t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        t.alu   = $urandom();
        t.mem   = $urandom();
        if (t.rst) begin t.stall = 0; t.flush = 0; end
        return t;
    endfunction

    // One clock of stimulus; the model result for the next edge goes to the scoreboard
    task automatic step(input txn_t t, input bit use_exp = 0, input bit [31:0] exp_data = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        stall          = t.stall;
        flush          = t.flush;
        inValid        = t.v;
        inRegWrite     = t.rw;
        inMemToReg     = t.m2r;
        inLoadSize     = t.sz;
        inLoadUnsigned = t.uns;
        inByteOff      = t.off;
        inRd           = t.rd;
        aluResult      = t.alu;
        memData        = t.mem;
        if (m_valid && !t.stall && !t.flush && m_cnt < CNT_MAX) m_cnt++;
        if (t.flush) begin
            m_valid = 0;
            m_known = 0;
        end else if (!t.stall) begin
            m_valid = t.v;
            m_known = 1;
            m_rw    = t.rw;
            m_rd    = t.rd;
            m_data  = t.m2r ? (use_exp ? exp_data : ref_load(t.mem, t.sz, t.uns, t.off)) : t.alu;
        end
        if (t.rst) begin
            m_valid = 0; m_known = 1; m_rw = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        end
        e.cyc   = cyc + 1;
        e.known = m_known;
        e.rw    = m_valid && m_rw && (m_rd != 0);
        e.rd    = m_rd;
        e.data  = m_data;
        e.cnt   = m_cnt;
        sb.push_back(e);
        if (t.rst) begin
            #4;
            reset = 1'b1;
            #1;
            check("async_rst_regWrite", 32'(regWrite), 32'd0);
            check("async_rst_rd", 32'(rd), 32'd0);
            check("async_rst_writeData", writeData, 32'd0);
            check("async_rst_retireCount", 32'(retireCount), 32'd0);
        end
    endtask

    // Monitor: compare the DUT against the scoreboard entry for this edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("retireCount", 32'(retireCount), 32'(e.cnt));
                check("regWrite", 32'(regWrite), 32'(e.rw));
                check("fwdValid", 32'(fwdValid), 32'(e.rw));
                if (e.known) begin
                    check("rd", 32'(rd), 32'(e.rd));
                    check("writeData", writeData, e.data);
                    check("fwdRd", 32'(fwdRd), 32'(e.rd));
                    check("fwdData", fwdData, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit [31:0] ld_exp [5];
        bit [1:0]  ld_sz  [5];
        bit        ld_uns [5];
        bit [1:0]  ld_off [5];
        ld_sz  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3};
        ld_uns = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ld_off = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1};
        ld_exp = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

        // Reset state, then a valid instruction hit by a mid-cycle reset
        step(idle());
        step(alu_op(5'd9, 32'hDEAD_BEEF));
        t = idle(); t.rst = 1;
        step(t);
        step(idle());
        step(idle());

        // ALU writeback and its retirement
        step(alu_op(5'd8, 32'h0000_1234));
        step(idle());
        step(idle());

        // Load alignment table
        for (int i = 0; i < 5; i++) begin
            t = alu_op(5'd3, 32'h1111_1111);
            t.m2r = 1; t.sz = ld_sz[i]; t.uns = ld_uns[i]; t.off = ld_off[i];
            t.mem = 32'h80FF_7F01;
            step(t, 1, ld_exp[i]);
        end

        // Write to r0 is squashed but still retires
        step(alu_op(5'd0, 32'hCAFE_0000));
        step(idle());

        // Stall for three cycles with new inputs pending
        step(alu_op(5'd5, 32'hA5A5_A5A5));
        for (int i = 0; i < 3; i++) begin
            t = alu_op(5'd6, 32'h1234_5678 + i);
            t.stall = 1;
            step(t);
        end
        step(alu_op(5'd6, 32'h0BAD_F00D));
        step(idle());

        // Stall and flush together: flush wins and nothing retires
        step(alu_op(5'd7, 32'h7777_7777));
        t = alu_op(5'd10, 32'h1010_1010);
        t.stall = 1; t.flush = 1;
        step(t);
        step(idle());

        // Randomised traffic
        for (int i = 0; i < 200; i++) step(rand_txn());

        // Saturation: retire more than the counter can hold
        t = idle(); t.rst = 1;
        step(t);
        for (int i = 0; i < CNT_MAX + 4; i++) step(alu_op(5'd1, 32'(i)));
        step(idle());
        step(idle());

        @(posedge clk);
        @(posedge clk);
        #4;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
